// File: rtl/updown_pkg.sv
// rtl/updown_pkg.sv - shared direction constants and debounce state encoding
// Used by updown_dir_ctrl, sync_debounce, the downstream counter and its bench.
package updown_pkg;

   localparam logic DIR_UP   = 1'b1;
   localparam logic DIR_DOWN = 1'b0;

   typedef enum logic [1:0] {
      IDLE_LOW  = 2'd0,
      WAIT_HIGH = 2'd1,
      IDLE_HIGH = 2'd2,
      WAIT_LOW  = 2'd3
   } deb_state_t;

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - 2-flop synchronizer plus debounce FSM for one raw input
// Ports:
//   clk      in  system clock, rising edge
//   rst      in  asynchronous active-high reset
//   raw      in  asynchronous, possibly bouncing level
//   clean    out accepted (debounced) level
//   rise_evt out combinational pulse on the cycle a high level is accepted;
//                the accepting state transition happens on the same clock edge
module sync_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic clean,
   output logic rise_evt
);
   import updown_pkg::*;

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_CYCLES);

   logic          sync1;
   logic          sync2;
   deb_state_t    state;
   deb_state_t    state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         state <= IDLE_LOW;
         cnt   <= '0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // cnt counts consecutive stable synchronized cycles while in a WAIT state;
   // entering a WAIT state already counts the first stable cycle.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      rise_evt  = 1'b0;
      case (state)
         IDLE_LOW: begin
            if (sync2) begin
               state_nxt = WAIT_HIGH;
               cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_HIGH: begin
            if (!sync2) begin
               state_nxt = IDLE_LOW;
               cnt_nxt   = '0;
            end else if (cnt == CNT_DONE) begin
               state_nxt = IDLE_HIGH;
               cnt_nxt   = '0;
               rise_evt  = 1'b1;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         IDLE_HIGH: begin
            if (!sync2) begin
               state_nxt = WAIT_LOW;
               cnt_nxt   = CNT_ONE;
            end
         end
         WAIT_LOW: begin
            if (sync2) begin
               state_nxt = IDLE_HIGH;
               cnt_nxt   = '0;
            end else if (cnt == CNT_DONE) begin
               state_nxt = IDLE_LOW;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + CNT_ONE;
            end
         end
         default: begin
            state_nxt = IDLE_LOW;
            cnt_nxt   = '0;
         end
      endcase
   end

   // The accepted level stays high until a low level has been accepted.
   assign clean = (state == IDLE_HIGH) || (state == WAIT_LOW);

endmodule

// File: rtl/updown_dir_ctrl.sv
// rtl/updown_dir_ctrl.sv - direction toggle and step-strobe control for the up/down counter
// Ports:
//   clk         in  system clock, rising edge
//   rst         in  asynchronous active-high reset
//   btn_dir     in  raw direction pushbutton (asynchronous, bouncing)
//   btn_hold    in  raw pause level (asynchronous), 1 = freeze counting
//   up_down     out registered direction, 1 = up, 0 = down
//   count_en    out registered one-cycle step strobe
//   dir_changed out one-cycle pulse in the first cycle of a new up_down value
module updown_dir_ctrl #(
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter int   TICK_DIV        = 10,
   parameter logic INIT_DIR        = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_dir,
   input  logic btn_hold,
   output logic up_down,
   output logic count_en,
   output logic dir_changed
);
   import updown_pkg::*;

   localparam int PW = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE  = PW'(1);

   logic          dir_clean;
   logic          dir_rise;
   logic          press;
   logic          hold_s1;
   logic          hold_s;
   logic [PW-1:0] presc;

   sync_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
   ) u_dir_deb (
      .clk      (clk),
      .rst      (rst),
      .raw      (btn_dir),
      .clean    (dir_clean),
      .rise_evt (dir_rise)
   );

   // An acceptance can only start from the low side, so this only ties the
   // toggle to a genuine low-to-high acceptance; releases never toggle.
   assign press = dir_rise & ~dir_clean;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_s1 <= 1'b0;
         hold_s  <= 1'b0;
      end else begin
         hold_s1 <= btn_hold;
         hold_s  <= hold_s1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         up_down     <= INIT_DIR;
         dir_changed <= 1'b0;
         count_en    <= 1'b0;
         presc       <= '0;
      end else begin
         dir_changed <= press;
         count_en    <= 1'b0;
         if (press) begin
            up_down <= ~up_down;
         end
         if (!hold_s) begin
            if (presc == PRESC_LAST) begin
               presc <= '0;
               // A direction change landing on the wrap swallows this step so the
               // first step in the new direction is a full period later.
               count_en <= ~press;
            end else begin
               presc <= presc + PRESC_ONE;
            end
         end
      end
   end

endmodule

// File: tb/tb_updown_dir_ctrl.sv
// tb/tb_updown_dir_ctrl.sv - directed scoreboard bench for updown_dir_ctrl
module tb_updown_dir_ctrl;
   import updown_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_dir = 1'b0;
   logic btn_hold = 1'b0;
   logic up_down;
   logic count_en;
   logic dir_changed;

   typedef struct {
      int   cyc;
      logic en;
      logic dc;
      logic ud;
   } ev_t;

   ev_t exp_q[$];
   int  cyc;
   int  n_vec = 0;
   int  n_err = 0;

   always #5 clk = ~clk;

   updown_dir_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .TICK_DIV       (10),
      .INIT_DIR       (1'b1)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_dir     (btn_dir),
      .btn_hold    (btn_hold),
      .up_down     (up_down),
      .count_en    (count_en),
      .dir_changed (dir_changed)
   );

   // cycle k = the k-th rising edge after reset release
   always @(posedge clk or posedge rst) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      assert (obs === exp_v)
      else begin
         n_err++;
         $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic push(input int c, input logic en, input logic dc, input logic ud);
      ev_t e;
      e = '{c, en, dc, ud};
      exp_q.push_back(e);
   endtask

   // Every output pulse is popped against the next expected event.
   always @(negedge clk) begin
      ev_t e;
      if (!rst && (count_en !== 1'b0 || dir_changed !== 1'b0)) begin
         n_vec++;
         assert (exp_q.size() != 0)
         else begin
            n_err++;
            $error("FAIL unexpected_pulse: cycle %0d en=%b dc=%b, expected no pulse",
                   cyc, count_en, dir_changed);
         end
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pulse_cycle", cyc, e.cyc);
            check("pulse_count_en", count_en, e.en);
            check("pulse_dir_changed", dir_changed, e.dc);
            check("pulse_up_down", up_down, e.ud);
         end
      end
   end

   task automatic wait_cyc(input int c);
      int guard = 0;
      while (cyc < c && guard < 1000) begin
         @(negedge clk);
         guard++;
      end
      check("wait_cycle_reached", (cyc >= c), 1);
   endtask

   task automatic end_test(input string tag);
      check({tag, "_pending_events"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // Reset asserted between edges so the checks prove the asynchronous clear.
   task automatic apply_reset();
      @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      check("rst_up_down", up_down, DIR_UP);
      check("rst_count_en", count_en, 0);
      check("rst_dir_changed", dir_changed, 0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, expected finish before 100000");
      $fatal(1);
   end

   initial begin
      logic [7:0] pat;

      // 1: idle inputs, steps every 10 cycles, direction stays up
      apply_reset();
      push(10, 1'b1, 1'b0, DIR_UP);
      push(20, 1'b1, 1'b0, DIR_UP);
      push(30, 1'b1, 1'b0, DIR_UP);
      wait_cyc(32);
      check("t1_up_down", up_down, DIR_UP);
      end_test("t1");

      // 2: long press sampled at cycle 3 -> flip at 9, release does nothing
      apply_reset();
      push(9,  1'b0, 1'b1, DIR_DOWN);
      push(10, 1'b1, 1'b0, DIR_DOWN);
      push(20, 1'b1, 1'b0, DIR_DOWN);
      push(30, 1'b1, 1'b0, DIR_DOWN);
      wait_cyc(2);
      btn_dir = 1'b1;
      wait_cyc(22);
      btn_dir = 1'b0;
      wait_cyc(35);
      check("t2_no_release_toggle", up_down, DIR_DOWN);
      end_test("t2");

      // 3: bounce never holds for 4 stable cycles -> no toggle
      apply_reset();
      push(10, 1'b1, 1'b0, DIR_UP);
      push(20, 1'b1, 1'b0, DIR_UP);
      pat = 8'b1110_1110;
      wait_cyc(2);
      for (int i = 7; i >= 0; i--) begin
         btn_dir = pat[i];
         @(negedge clk);
      end
      btn_dir = 1'b0;
      wait_cyc(22);
      check("t3_up_down", up_down, DIR_UP);
      end_test("t3");

      // 4: hold freezes prescaler at 3 for 25 cycles; resumes 7 cycles after hold_s drops
      apply_reset();
      push(10, 1'b1, 1'b0, DIR_UP);
      push(45, 1'b1, 1'b0, DIR_UP);
      push(55, 1'b1, 1'b0, DIR_UP);
      wait_cyc(11);
      btn_hold = 1'b1;
      wait_cyc(36);
      btn_hold = 1'b0;
      wait_cyc(57);
      end_test("t4");

      // 5: press lands on the wrap edge (cycle 20): step swallowed, next 10 later
      apply_reset();
      push(10, 1'b1, 1'b0, DIR_UP);
      push(20, 1'b0, 1'b1, DIR_DOWN);
      push(30, 1'b1, 1'b0, DIR_DOWN);
      push(40, 1'b1, 1'b0, DIR_DOWN);
      wait_cyc(13);
      btn_dir = 1'b1;
      wait_cyc(25);
      btn_dir = 1'b0;
      wait_cyc(42);
      end_test("t5");

      // 6: reset in WAIT_HIGH with button held -> press counted 2+4 after release
      apply_reset();
      wait_cyc(2);
      btn_dir = 1'b1;
      wait_cyc(6);
      end_test("t6_pre");
      apply_reset();
      push(7,  1'b0, 1'b1, DIR_DOWN);
      push(10, 1'b1, 1'b0, DIR_DOWN);
      push(20, 1'b1, 1'b0, DIR_DOWN);
      wait_cyc(22);
      check("t6_up_down", up_down, DIR_DOWN);
      btn_dir = 1'b0;
      end_test("t6");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
